// File: rtl/reg_write_arbiter_if.sv
// Bus between N requesters and the register-bank write arbiter.
//   Req        per-requester write request
//   WrData     packed per-requester write data, requester i at [i*DATA_W +: DATA_W]
//   WrAddr     packed per-requester address, requester i at [i*ADDR_W +: ADDR_W]
//   Grant      one-cycle completion acknowledge (at most one bit high)
//   RegEn      one-hot register load enable
//   RegData    data presented to the register bank
//   Busy       arbiter is mid-transaction
//   WriteCount completed writes, modulo 256
// master: requester/bank side, slave: arbiter side.
interface reg_write_arbiter_if #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 2
);
    logic [N_REQ-1:0]          Req;
    logic [N_REQ*DATA_W-1:0]   WrData;
    logic [N_REQ*ADDR_W-1:0]   WrAddr;
    logic [N_REQ-1:0]          Grant;
    logic [(1<<ADDR_W)-1:0]    RegEn;
    logic [DATA_W-1:0]         RegData;
    logic                      Busy;
    logic [7:0]                WriteCount;

    modport master (
        output Req, WrData, WrAddr,
        input  Grant, RegEn, RegData, Busy, WriteCount
    );

    modport slave (
        input  Req, WrData, WrAddr,
        output Grant, RegEn, RegData, Busy, WriteCount
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter serialising requester writes into a register bank.
// Each accepted write takes three cycles: IDLE (arbitrate + latch),
// LOAD (RegEn/RegData to the bank), ACK (Grant to the winner).
//   Clk    rising-edge clock
//   Reset  synchronous, active-high
//   bus    reg_write_arbiter_if.slave (Req/WrData/WrAddr in,
//          Grant/RegEn/RegData/Busy/WriteCount out, all registered)
module reg_write_arbiter #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 2
) (
    input  logic                 Clk,
    input  logic                 Reset,
    reg_write_arbiter_if.slave   bus
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned N_REG = 1 << ADDR_W;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    win_q, win_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic [N_REG-1:0]    reg_en_q, reg_en_d;
    logic [DATA_W-1:0]   reg_data_q, reg_data_d;
    logic                busy_q, busy_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic                found;
    logic [IDX_W-1:0]    pick;
    logic [IDX_W-1:0]    cand;
    logic [DATA_W-1:0]   pick_data;
    logic [ADDR_W-1:0]   pick_addr;

    // Round-robin search: first active request at or above ptr_q, wrapping to 0.
    always_comb begin : rr_pick
        found = 1'b0;
        pick  = ptr_q;
        cand  = ptr_q;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = IDX_W'((32'(ptr_q) + k) % N_REQ);
            if (!found && bus.Req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        pick_data = bus.WrData[32'(pick)*DATA_W +: DATA_W];
        pick_addr = bus.WrAddr[32'(pick)*ADDR_W +: ADDR_W];
    end

    // Next state and next registered outputs; the RegEn/RegData registers
    // double as the latch for the winner's address and data.
    always_comb begin : fsm_next
        state_d    = state_q;
        ptr_d      = ptr_q;
        win_d      = win_q;
        grant_d    = '0;
        reg_en_d   = '0;
        reg_data_d = '0;
        busy_d     = 1'b0;
        count_d    = count_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = LOAD;
                    win_d      = pick;
                    reg_en_d   = N_REG'(1) << pick_addr;
                    reg_data_d = pick_data;
                    busy_d     = 1'b1;
                end
            end
            LOAD: begin
                // Completion is committed here so a reset in LOAD leaves no trace.
                state_d = ACK;
                grant_d = N_REQ'(1) << win_q;
                busy_d  = 1'b1;
                count_d = count_q + CNT_W'(1);
                ptr_d   = (win_q == IDX_W'(N_REQ - 1)) ? '0 : win_q + IDX_W'(1);
            end
            ACK: begin
                // Always return to IDLE so a still-high Req must re-arbitrate.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge Clk) begin : fsm_reg
        if (Reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            win_q      <= '0;
            grant_q    <= '0;
            reg_en_q   <= '0;
            reg_data_q <= '0;
            busy_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            win_q      <= win_d;
            grant_q    <= grant_d;
            reg_en_q   <= reg_en_d;
            reg_data_q <= reg_data_d;
            busy_q     <= busy_d;
            count_q    <= count_d;
        end
    end

    assign bus.Grant      = grant_q;
    assign bus.RegEn      = reg_en_q;
    assign bus.RegData    = reg_data_q;
    assign bus.Busy       = busy_q;
    assign bus.WriteCount = count_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a write/grant scoreboard.
module tb_reg_write_arbiter;

    localparam int unsigned N_REQ  = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    reg_write_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

    reg_write_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    typedef struct {
        int unsigned idx;
        logic [1:0]  addr;
        logic [7:0]  data;
        logic [7:0]  cnt;
        bit          abort;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] exp_cnt = 8'd0;
    logic [7:0] bank [4];
    int         checks = 0;
    int         errors = 0;
    int         grant_pulses = 0;
    int         regen_pulses = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int unsigned i, input logic [1:0] a, input logic [7:0] d);
        bus.WrAddr[i*ADDR_W +: ADDR_W] = a;
        bus.WrData[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic expect_write(input int unsigned i, input logic [1:0] a,
                                input logic [7:0] d, input bit ab);
        exp_t e;
        if (!ab) exp_cnt = exp_cnt + 8'd1;
        e.idx = i; e.addr = a; e.data = d; e.cnt = exp_cnt; e.abort = ab;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.Req = '0;
        tick();
        tick();
        rst = 1'b0;
        exp_cnt = 8'd0;
    endtask

    // Advance at least one cycle, then until a Grant appears or the bound expires.
    task automatic wait_grant(input int unsigned i, input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (bus.Grant == '0 && n < 3*N_REQ + 3);
        check(tag, 32'(bus.Grant), 32'(1) << i);
    endtask

    // Requester drops Req in the cycle after its Grant.
    task automatic release_req(input int unsigned i);
        tick();
        bus.Req[i] = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_grant"},   32'(bus.Grant),   32'd0);
        check({tag, "_regen"},   32'(bus.RegEn),   32'd0);
        check({tag, "_regdata"}, 32'(bus.RegData), 32'd0);
        check({tag, "_busy"},    32'(bus.Busy),    32'd0);
    endtask

    // Scoreboard: RegEn/RegData matched against the head entry, Grant pops it.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.RegEn != '0) begin
            regen_pulses++;
            if (exp_q.size() == 0) begin
                check("sb_unexpected_regen", 32'(bus.RegEn), 32'd0);
            end else begin
                e = exp_q[0];
                check("sb_regen",    32'(bus.RegEn),   32'(1) << e.addr);
                check("sb_regdata",  32'(bus.RegData), 32'(e.data));
                if (e.abort) void'(exp_q.pop_front());
            end
        end
        if (bus.Grant != '0) begin
            grant_pulses++;
            if (exp_q.size() == 0) begin
                check("sb_unexpected_grant", 32'(bus.Grant), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_grant", 32'(bus.Grant),      32'(1) << e.idx);
                check("sb_count", 32'(bus.WriteCount), 32'(e.cnt));
            end
        end
    end

    always @(posedge clk) begin : bank_model
        for (int k = 0; k < 4; k++)
            if (bus.RegEn[k]) bank[k] <= bus.RegData;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int g0;
        int r0;

        bus.Req    = '0;
        bus.WrData = '0;
        bus.WrAddr = '0;

        // Reset values
        rst = 1'b1;
        tick();
        tick();
        check_idle("reset");
        check("reset_count", 32'(bus.WriteCount), 32'd0);
        rst = 1'b0;
        tick();
        check_idle("idle_noreq");

        // Single request: RegEn one cycle after sampling, Grant one cycle later
        drive(1, 2'd3, 8'hA5);
        expect_write(1, 2'd3, 8'hA5, 1'b0);
        bus.Req = 4'b0010;
        tick();
        check("s1_regen",   32'(bus.RegEn),   32'h8);
        check("s1_regdata", 32'(bus.RegData), 32'hA5);
        check("s1_busy",    32'(bus.Busy),    32'd1);
        check("s1_nogrant", 32'(bus.Grant),   32'd0);
        tick();
        check("s1_grant",   32'(bus.Grant),      32'h2);
        check("s1_count",   32'(bus.WriteCount), 32'd1);
        check("s1_busy_ack", 32'(bus.Busy),      32'd1);
        check("s1_regen_ack", 32'(bus.RegEn),    32'd0);
        release_req(1);
        check_idle("s1_after");
        tick();
        check_idle("s1_idle");

        // All four requesting: 0,1,2,3,0 each three cycles apart
        do_reset();
        for (int i = 0; i < 4; i++) drive(i, 2'(i), 8'h10 + 8'(i));
        for (int g = 0; g < 5; g++) expect_write(g % 4, 2'(g % 4), 8'h10 + 8'(g % 4), 1'b0);
        bus.Req = 4'hF;
        tick();
        tick();
        check("s2_grant0", 32'(bus.Grant), 32'h1);
        for (int g = 1; g < 5; g++) begin
            tick();
            tick();
            tick();
            check("s2_grant_rr", 32'(bus.Grant), 32'(1) << (g % 4));
        end
        bus.Req = '0;
        tick();
        tick();
        check_idle("s2_idle");
        check("s2_count", 32'(bus.WriteCount), 32'd5);

        // Pointer wrap: after granting 2, requester 3 wins over 0
        do_reset();
        drive(2, 2'd0, 8'h20);
        expect_write(2, 2'd0, 8'h20, 1'b0);
        bus.Req = 4'b0100;
        wait_grant(2, "s3_grant2");
        release_req(2);
        drive(0, 2'd1, 8'h30);
        drive(3, 2'd2, 8'h33);
        expect_write(3, 2'd2, 8'h33, 1'b0);
        expect_write(0, 2'd1, 8'h30, 1'b0);
        bus.Req = 4'b1001;
        wait_grant(3, "s3_grant3_first");
        release_req(3);
        wait_grant(0, "s3_grant0_second");
        release_req(0);

        // Req and data dropped during LOAD: the latched write still completes
        drive(0, 2'd1, 8'h3C);
        expect_write(0, 2'd1, 8'h3C, 1'b0);
        bus.Req = 4'b0001;
        tick();
        bus.Req = '0;
        drive(0, 2'd1, 8'h00);
        check("s4_regdata_latched", 32'(bus.RegData), 32'h3C);
        tick();
        check("s4_grant", 32'(bus.Grant), 32'h1);
        check("s4_count", 32'(bus.WriteCount), 32'd4);
        tick();
        check_idle("s4_idle");

        // Same address from two requesters: last grantee's data remains
        do_reset();
        drive(1, 2'd2, 8'h11);
        drive(2, 2'd2, 8'h22);
        expect_write(1, 2'd2, 8'h11, 1'b0);
        expect_write(2, 2'd2, 8'h22, 1'b0);
        bus.Req = 4'b0110;
        wait_grant(1, "s5_grant1");
        release_req(1);
        wait_grant(2, "s5_grant2");
        release_req(2);
        check("s5_bank_last", 32'(bank[2]), 32'h22);

        // Reset during LOAD aborts the write
        do_reset();
        drive(1, 2'd0, 8'h5A);
        expect_write(1, 2'd0, 8'h5A, 1'b1);
        bus.Req = 4'b0010;
        tick();
        rst = 1'b1;
        bus.Req = '0;
        tick();
        check_idle("s6_in_reset");
        check("s6_count_reset", 32'(bus.WriteCount), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_idle("s6_after");
            check("s6_count", 32'(bus.WriteCount), 32'd0);
        end
        check("s6_queue_empty", 32'(exp_q.size()), 32'd0);

        // Request accepted in the first cycle after reset release
        do_reset();
        drive(2, 2'd3, 8'h77);
        expect_write(2, 2'd3, 8'h77, 1'b0);
        bus.Req = 4'b0100;
        tick();
        check("s7_regen_first", 32'(bus.RegEn), 32'h8);
        tick();
        check("s7_grant", 32'(bus.Grant), 32'h4);
        release_req(2);

        // 256 back-to-back writes: WriteCount wraps to 0
        do_reset();
        g0 = grant_pulses;
        r0 = regen_pulses;
        bus.Req = 4'b0001;
        for (int i = 0; i < 256; i++) begin
            drive(0, 2'(i), 8'(i));
            expect_write(0, 2'(i), 8'(i), 1'b0);
            wait_grant(0, "s8_grant");
        end
        bus.Req = '0;
        tick();
        tick();
        check("s8_count_wrap",  32'(bus.WriteCount),  32'd0);
        check("s8_grant_pulses", 32'(grant_pulses - g0), 32'd256);
        check("s8_regen_pulses", 32'(regen_pulses - r0), 32'd256);
        check_idle("s8_idle");

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
